// File: rtl/cursor_move_ctrl_pkg.sv
// Shared definitions for the cursor mover: debounce state encoding, key indices,
// default screen size and the wrap-around step helpers.
package cursor_move_ctrl_pkg;

    typedef enum logic [1:0] {
        DB_REL = 2'd0,
        DB_PW  = 2'd1,
        DB_PRS = 2'd2,
        DB_RW  = 2'd3
    } db_state_t;

    localparam int H_MAX_DEF = 640;
    localparam int V_MAX_DEF = 480;
    localparam int NUM_KEYS  = 4;

    localparam int K_LEFT  = 3;
    localparam int K_UP    = 2;
    localparam int K_DOWN  = 1;
    localparam int K_RIGHT = 0;

    // 11-bit intermediates keep v+step and v+lim-step from overflowing.
    function automatic logic [9:0] wrap_dec(input logic [9:0] v, input logic [10:0] step,
                                            input logic [10:0] lim);
        logic [10:0] w;
        w = {1'b0, v};
        if (w < step)
            return 10'(w + lim - step);
        return 10'(w - step);
    endfunction

    function automatic logic [9:0] wrap_inc(input logic [9:0] v, input logic [10:0] step,
                                            input logic [10:0] lim);
        logic [10:0] w;
        w = {1'b0, v} + step;
        if (w >= lim)
            return 10'(w - lim);
        return 10'(w);
    endfunction

endpackage

// File: rtl/cursor_move_ctrl_key_debounce.sv
// One push button: 2-flop synchroniser, then a REL/PW/PRS/RW debounce FSM.
// key_db is high in PRS and RW.
module key_debounce
    import cursor_move_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_db
);

    localparam int CW = ($clog2(DB_CYCLES) > 0) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          key_s1;
    logic          key_s2;
    logic          pressed;
    logic [CW-1:0] cnt;
    db_state_t     state;

    assign pressed = ~key_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            state  <= DB_REL;
            cnt    <= '0;
            key_db <= 1'b0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            case (state)
                DB_REL: if (pressed) begin
                    state <= DB_PW;
                    cnt   <= '0;
                end
                DB_PW: if (!pressed) begin
                    state <= DB_REL;
                    cnt   <= '0;
                end else if (cnt == CNT_LAST) begin
                    state  <= DB_PRS;
                    cnt    <= '0;
                    key_db <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DB_PRS: if (!pressed) begin
                    state <= DB_RW;
                    cnt   <= '0;
                end
                // key_db stays high through RW so a bounce on release is not a new press
                DB_RW: if (pressed) begin
                    state <= DB_PRS;
                    cnt   <= '0;
                end else if (cnt == CNT_LAST) begin
                    state  <= DB_REL;
                    cnt    <= '0;
                    key_db <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= DB_REL;
            endcase
        end
    end

endmodule

// File: rtl/cursor_move_ctrl.sv
// Moves a shadow cursor position from debounced keys with auto-repeat, and commits it
// to the overlay registers on the falling edge of vertical sync.
module cursor_move_ctrl
    import cursor_move_ctrl_pkg::*;
#(
    parameter int H_MAX      = H_MAX_DEF,
    parameter int V_MAX      = V_MAX_DEF,
    parameter int STEP       = 2,
    parameter int DB_CYCLES  = 500000,
    parameter int TICK_DIV   = 1048576,
    parameter int REPEAT_DLY = 8,
    parameter int INIT_COL   = 320,
    parameter int INIT_ROW   = 240
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] KEY,
    input  logic       FRAME_VS,
    output logic [9:0] cur_col,
    output logic [9:0] cur_row,
    output logic       pending,
    output logic       commit,
    output logic [3:0] key_db
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = ($clog2(REPEAT_DLY + 1) > 0) ? $clog2(REPEAT_DLY + 1) : 1;

    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [HW-1:0]       hold_cnt;
    logic [NUM_KEYS-1:0] key_db_q;
    logic [NUM_KEYS-1:0] rise;
    logic                any_key;
    logic                step;
    logic                vs_s1, vs_s2, vs_s3;
    logic                vs_fall;
    logic [9:0]          shadow_col, shadow_row;
    logic [9:0]          nxt_col, nxt_row;
    logic [9:0]          nxt_cur_col, nxt_cur_row;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (CLOCK_50),
            .rst_n  (RESET_N),
            .key_n  (KEY[i]),
            .key_db (key_db[i])
        );
    end

    always_comb begin
        tick    = (tick_cnt == TW'(TICK_DIV - 1));
        rise    = key_db & ~key_db_q;
        any_key = |key_db;
        step    = (|rise) || (tick && any_key && (hold_cnt == HW'(REPEAT_DLY)));
        vs_fall = vs_s3 & ~vs_s2;

        nxt_col = shadow_col;
        nxt_row = shadow_row;
        if (step) begin
            if (&key_db) begin
                nxt_col = 10'(INIT_COL);
                nxt_row = 10'(INIT_ROW);
            end else begin
                // opposing keys cancel on their axis
                if (key_db[K_LEFT] && !key_db[K_RIGHT])
                    nxt_col = wrap_dec(shadow_col, 11'(STEP), 11'(H_MAX));
                else if (key_db[K_RIGHT] && !key_db[K_LEFT])
                    nxt_col = wrap_inc(shadow_col, 11'(STEP), 11'(H_MAX));
                if (key_db[K_UP] && !key_db[K_DOWN])
                    nxt_row = wrap_dec(shadow_row, 11'(STEP), 11'(V_MAX));
                else if (key_db[K_DOWN] && !key_db[K_UP])
                    nxt_row = wrap_inc(shadow_row, 11'(STEP), 11'(V_MAX));
            end
        end

        // commit captures the shadow before this cycle's step lands
        nxt_cur_col = vs_fall ? shadow_col : cur_col;
        nxt_cur_row = vs_fall ? shadow_row : cur_row;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_cnt   <= '0;
            hold_cnt   <= '0;
            key_db_q   <= '0;
            vs_s1      <= 1'b1;
            vs_s2      <= 1'b1;
            vs_s3      <= 1'b1;
            shadow_col <= 10'(INIT_COL);
            shadow_row <= 10'(INIT_ROW);
            cur_col    <= 10'(INIT_COL);
            cur_row    <= 10'(INIT_ROW);
            pending    <= 1'b0;
            commit     <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            key_db_q <= key_db;
            vs_s1    <= FRAME_VS;
            vs_s2    <= vs_s1;
            vs_s3    <= vs_s2;

            if (!any_key || (|rise))
                hold_cnt <= '0;
            else if (tick && (hold_cnt != HW'(REPEAT_DLY)))
                hold_cnt <= hold_cnt + 1'b1;

            shadow_col <= nxt_col;
            shadow_row <= nxt_row;
            cur_col    <= nxt_cur_col;
            cur_row    <= nxt_cur_row;
            pending    <= (nxt_col != nxt_cur_col) || (nxt_row != nxt_cur_row);
            commit     <= vs_fall;
        end
    end

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Randomised key/VS stimulus against a behavioural cursor model; committed positions
// are queued by the model and popped by a monitor on each DUT commit pulse.
module tb_cursor_move_ctrl;

    localparam int H = 640, V = 480, ST = 2, DB = 4, TD = 16, RD = 2, IC = 320, IR = 240;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic [3:0] KEY      = 4'hF;
    logic       FRAME_VS = 1'b1;
    logic [9:0] cur_col, cur_row;
    logic       pending, commit;
    logic [3:0] key_db;

    cursor_move_ctrl #(
        .H_MAX(H), .V_MAX(V), .STEP(ST), .DB_CYCLES(DB), .TICK_DIV(TD),
        .REPEAT_DLY(RD), .INIT_COL(IC), .INIT_ROW(IR)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY      (KEY),
        .FRAME_VS (FRAME_VS),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .pending  (pending),
        .commit   (commit),
        .key_db   (key_db)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int col;
        int row;
    } pos_t;

    int   tests = 0;
    int   fails = 0;
    pos_t sbq[$];
    pos_t exp_p;

    // reference model state (pressed-high key sense)
    int         s_col, s_row, m_col, m_row, hold, cyc;
    int         run[4];
    logic [3:0] db, db_prev, last_p, kd1, kd2;
    logic       v1, v2, v3;
    logic       m_commit, m_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        s_col = IC; s_row = IR; m_col = IC; m_row = IR;
        hold = 0; cyc = 0;
        for (int i = 0; i < 4; i++) run[i] = 0;
        db = '0; db_prev = '0; last_p = '0;
        kd1 = 4'hF; kd2 = 4'hF;
        v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
        m_commit = 1'b0; m_pend = 1'b0;
        sbq.delete();
    endtask

    // One clock edge of the spec: key held/released for DB+1 synced samples flips the
    // debounced state; a press or a repeat tick moves the shadow modulo the screen size.
    task automatic model_step();
        logic [3:0] p, rise;
        logic       tick, step, fall;
        int         nc, nr;
        p    = ~kd2;
        rise = db & ~db_prev;
        tick = (cyc % TD) == TD - 1;
        step = (rise != 0) || (tick && db != 0 && hold == RD);
        nc = s_col;
        nr = s_row;
        if (step) begin
            if (db == 4'hF) begin
                nc = IC; nr = IR;
            end else begin
                if (db[3] && !db[0]) nc = (s_col - ST + H) % H;
                else if (db[0] && !db[3]) nc = (s_col + ST) % H;
                if (db[2] && !db[1]) nr = (s_row - ST + V) % V;
                else if (db[1] && !db[2]) nr = (s_row + ST) % V;
            end
        end
        if (db == 0 || rise != 0) hold = 0;
        else if (tick && hold < RD) hold++;

        fall     = v3 && !v2;
        m_commit = fall;
        if (fall) begin
            m_col = s_col;
            m_row = s_row;
            sbq.push_back('{s_col, s_row});
        end
        s_col  = nc;
        s_row  = nr;
        m_pend = (s_col != m_col) || (s_row != m_row);

        db_prev = db;
        for (int i = 0; i < 4; i++) begin
            if (p[i] == last_p[i]) run[i]++;
            else run[i] = 1;
            last_p[i] = p[i];
            if (run[i] >= DB + 1 && p[i] != db[i]) db[i] = p[i];
        end
        kd2 = kd1; kd1 = KEY;
        v3 = v2; v2 = v1; v1 = FRAME_VS;
        cyc++;
    endtask

    initial begin
        forever begin
            @(posedge CLOCK_50);
            if (!RESET_N) model_reset();
            else model_step();
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge CLOCK_50);
            chk("key_db", 32'(key_db), 32'(db));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("commit", 32'(commit), 32'(m_commit));
            chk("cur_col_hold", 32'(cur_col), 32'(m_col));
            chk("cur_row_hold", 32'(cur_row), 32'(m_row));
            if (commit === 1'b1) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got commit expected none (t=%0t)", $time);
                end else begin
                    exp_p = sbq.pop_front();
                    chk("sb_col", 32'(cur_col), 32'(exp_p.col));
                    chk("sb_row", 32'(cur_row), 32'(exp_p.row));
                end
            end
        end
    end

    // free-running vertical sync, including 1-cycle low pulses
    initial begin
        forever begin
            repeat ($urandom_range(20, 100)) @(negedge CLOCK_50);
            FRAME_VS = 1'b0;
            repeat ($urandom_range(1, 25)) @(negedge CLOCK_50);
            FRAME_VS = 1'b1;
        end
    end

    task automatic hold_keys(input logic [3:0] pressed, input int n);
        KEY = ~pressed;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic rand_segments(input int n);
        logic [3:0] combo;
        int         r;
        repeat (n) begin
            r = $urandom_range(0, 15);
            if (r < 8) combo = 4'b0001 << $urandom_range(0, 3);
            else if (r < 10) combo = 4'b0000;
            else combo = 4'($urandom_range(1, 15));
            hold_keys(combo, $urandom_range(1, 70));
        end
    endtask

    initial begin
        model_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        chk("rst_col", 32'(cur_col), IC);
        chk("rst_row", 32'(cur_row), IR);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_key_db", 32'(key_db), 0);

        hold_keys(4'b0000, 200);
        // glitch, then a clean right press
        hold_keys(4'b0001, 2);
        hold_keys(4'b0000, 4);
        hold_keys(4'b0001, 20);
        hold_keys(4'b0000, 150);

        rand_segments(150);

        // long holds drive every axis across its wrap point
        hold_keys(4'b1000, 2800); hold_keys(4'b0000, 40);
        hold_keys(4'b0001, 3000); hold_keys(4'b0000, 40);
        hold_keys(4'b0010, 2200); hold_keys(4'b0000, 40);
        hold_keys(4'b0100, 2200); hold_keys(4'b0000, 40);
        hold_keys(4'b0100, 100);  hold_keys(4'b0000, 40);
        hold_keys(4'b0100, 120);  // drifted, so recentre has something to do
        hold_keys(4'b1111, 200);  hold_keys(4'b0000, 40);
        hold_keys(4'b1001, 300);  hold_keys(4'b0000, 40);
        hold_keys(4'b1101, 300);  hold_keys(4'b0000, 150);

        // reset while left is held and up is still debouncing
        hold_keys(4'b1000, 100);
        KEY = ~4'b1100;
        @(posedge CLOCK_50);
        #2 RESET_N = 1'b0;
        model_reset();
        #1;
        chk("midrst_col", 32'(cur_col), IC);
        chk("midrst_row", 32'(cur_row), IR);
        chk("midrst_pending", 32'(pending), 0);
        chk("midrst_commit", 32'(commit), 0);
        chk("midrst_key_db", 32'(key_db), 0);
        repeat (3) @(negedge CLOCK_50);
        KEY = 4'hF;
        RESET_N = 1'b1;

        rand_segments(60);
        hold_keys(4'b0000, 300);
        chk("sb_drain", 32'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
